oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 32 +++
 rtl/oam_dma.sv | 127 ++++++++++++
 tb/tb_oam_dma.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// ---------------------------------------------------------------------------
// oam_dma_pkg -- shared definitions for the sprite (OAM) DMA engine.
//
// Holds the FSM state type, the state encodings and the default trigger and
// destination addresses that oam_dma uses as its parameter defaults.
// Also supplies default bus widths (`ADDR_WIDTH / `REG_WIDTH) when the
// enclosing build has not already defined them.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package oam_dma_pkg;

    // CPU write to this address starts a transfer; the written byte is the page.
    localparam logic [15:0] OAM_DMA_TRIGGER_ADDR = 16'h4014;
    // Every DMA write lands here (PPU OAM data port).
    localparam logic [15:0] OAM_DATA_ADDR        = 16'h2004;

    typedef logic [2:0] dma_state_t;

    localparam dma_state_t IDLE  = 3'd0;
    localparam dma_state_t HALT  = 3'd1;
    localparam dma_state_t ALIGN = 3'd2;
    localparam dma_state_t READ  = 3'd3;
    localparam dma_state_t WRITE = 3'd4;
    localparam dma_state_t DONE  = 3'd5;

endpackage

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- sprite DMA: copies XFER_LEN bytes from page {cpu_d,8'h00} to
// the fixed DEST_ADDR port while holding the CPU off the bus.
//
// Ports
//   clk        in   single clock
//   reset      in   synchronous, active-high
//   cpu_addr   in   CPU address, snooped for TRIGGER_ADDR
//   cpu_d      in   CPU write data (source page)
//   cpu_r_w_n  in   CPU read/write strobe (0 = write)
//   rdy        out  CPU ready; 0 halts the CPU
//   bus_oe     out  1 = DMA owns the bus (mux lives in cpu_top)
//   bus_addr   out  DMA address
//   bus_r_w_n  out  DMA read/write (1 = read)
//   bus_dout   out  DMA write data
//   bus_din    in   read data, returned in the same cycle
//   done       out  one-cycle pulse at transfer end
//
// Build option
//   OAM_DMA_ALIGN_EN  when defined, a start that sees parity=1 in HALT
//                     inserts one ALIGN cycle before the first READ.
// ---------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_TRIGGER_ADDR,
    parameter logic [15:0] DEST_ADDR    = OAM_DATA_ADDR,
    parameter int          XFER_LEN     = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`ADDR_WIDTH-1:0] cpu_addr,
    input  logic [`REG_WIDTH-1:0]  cpu_d,
    input  logic                   cpu_r_w_n,
    output logic                   rdy,
    output logic                   bus_oe,
    output logic [`ADDR_WIDTH-1:0] bus_addr,
    output logic                   bus_r_w_n,
    output logic [`REG_WIDTH-1:0]  bus_dout,
    input  logic [`REG_WIDTH-1:0]  bus_din,
    output logic                   done
);

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    // idx of the final byte; idx is 8 bits so 256 maps to 8'hFF.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t           state_q, state_d;
    logic [7:0]           page_q,  page_d;
    logic [7:0]           idx_q,   idx_d;
    logic [`REG_WIDTH-1:0] data_q, data_d;
    logic                 parity_q;

    logic trigger;
    assign trigger = !cpu_r_w_n && (cpu_addr == TRIGGER_ADDR);

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = cpu_d;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            // HALT lets the CPU finish its trigger write before we take the bus.
            HALT:  state_d = (ALIGN_ON && parity_q) ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
                data_d  = bus_din;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_q + 8'd1;   // wraps in-page
                state_d = (idx_q == LAST_IDX) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            page_q   <= 8'd0;
            idx_q    <= 8'd0;
            data_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

    // Outputs are gated by reset directly so an in-flight transfer releases
    // the bus and the CPU in the reset cycle itself, not one cycle later.
    logic in_read, in_write;
    assign in_read  = !reset && (state_q == READ);
    assign in_write = !reset && (state_q == WRITE);

    assign rdy       = reset || (state_q == IDLE) || (state_q == DONE);
    assign bus_oe    = in_read || in_write;
    assign bus_r_w_n = !in_write;
    assign bus_dout  = in_write ? data_q : '0;
    assign done      = !reset && (state_q == DONE);

    always_comb begin
        bus_addr = '0;
        if (in_read)
            bus_addr = `ADDR_WIDTH'({page_q, idx_q});
        else if (in_write)
            bus_addr = `ADDR_WIDTH'(DEST_ADDR);
    end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_d = 8'h00;
    logic        cpu_r_w_n = 1'b1;
    logic        rdy, bus_oe, bus_r_w_n, dma_done;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, bus_din;

    oam_dma dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_r_w_n(cpu_r_w_n), .rdy(rdy), .bus_oe(bus_oe), .bus_addr(bus_addr),
        .bus_r_w_n(bus_r_w_n), .bus_dout(bus_dout), .bus_din(bus_din),
        .done(dma_done)
    );

    always #5 clk = ~clk;

    // Same-cycle memory: mem[a] = a[7:0] ^ a[15:8] ^ 8'hA7, so page 02 gives i^A5.
    assign bus_din = bus_addr[7:0] ^ bus_addr[15:8] ^ 8'hA7;

    // Reference free-running parity: 0 out of reset, toggles every edge.
    logic par_m;
    always @(posedge clk) par_m <= reset ? 1'b0 : ~par_m;

    // Bus monitor, sampled on the falling edge.
    int rdy_low = 0, done_cnt = 0, bad_wa = 0, bus_bad = 0;
    logic [7:0]  wr_log[$];
    logic [15:0] rd_log[$];
    always @(negedge clk) begin
        if (!rdy) rdy_low++;
        if (dma_done) done_cnt++;
        if (bus_oe && !bus_r_w_n) begin
            wr_log.push_back(bus_dout);
            if (bus_addr != 16'h2004) bad_wa++;
        end
        if (bus_oe && bus_r_w_n) rd_log.push_back(bus_addr);
        if (!bus_oe && (bus_addr != 16'h0 || bus_dout != 8'h0 || !bus_r_w_n)) bus_bad++;
    end

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int b_rdy, b_done, b_wr, b_rd, b_wa, b_bus;
    task automatic snap();
        b_rdy = rdy_low; b_done = done_cnt; b_wr = wr_log.size(); b_rd = rd_log.size();
        b_wa = bad_wa; b_bus = bus_bad;
    endtask

    // One-cycle CPU write, driven from a falling edge.
    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_d = d; cpu_r_w_n = 1'b0;
        @(negedge clk);
        cpu_addr = 16'h0000; cpu_r_w_n = 1'b1;
    endtask

    // Trigger so that the HALT cycle sees parity == hp.
    task automatic trig(input logic [7:0] page, input logic hp);
        @(negedge clk);
        if (par_m == hp) @(negedge clk);
        cpu_wr(16'h4014, page);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] page, input logic hp);
        int errs;
        int n;
        errs = 0;
        n = wr_log.size() - b_wr;
        chk({tag, "_rdylow"}, rdy_low - b_rdy, 513 + ((AL && hp) ? 1 : 0));
        chk({tag, "_done"},   done_cnt - b_done, 1);
        chk({tag, "_nwr"},    n, 256);
        chk({tag, "_nrd"},    rd_log.size() - b_rd, 256);
        chk({tag, "_wraddr"}, bad_wa - b_wa, 0);
        chk({tag, "_busidle"}, bus_bad - b_bus, 0);
        if (rd_log.size() - b_rd == 256) begin
            chk({tag, "_rd0"},   rd_log[b_rd], {page, 8'h00});
            chk({tag, "_rdlast"}, rd_log[b_rd + 255], {page, 8'hFF});
        end
        for (int i = 0; i < n && i < 256; i++)
            if (wr_log[b_wr + i] !== (8'(i) ^ page ^ 8'hA7)) errs++;
        chk({tag, "_data"}, errs, 0);
    endtask

    initial begin
        int w;
        bit hit;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy, 1);
        chk("rst_oe", bus_oe, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_rwn", bus_r_w_n, 1);
        chk("rst_addr", bus_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // basic page 02, HALT parity 0
        snap(); trig(8'h02, 1'b0); repeat (600) @(negedge clk);
        check_xfer("p02", 8'h02, 1'b0);

        // HALT parity 1: ALIGN cycle only when the option is built in
        snap(); trig(8'h02, 1'b1); repeat (600) @(negedge clk);
        check_xfer("p02al", 8'h02, 1'b1);

        // top page, idx wraps inside the page
        snap(); trig(8'hFF, 1'b0); repeat (600) @(negedge clk);
        check_xfer("pFF", 8'hFF, 1'b0);
        begin
            int bad;
            bad = 0;
            for (int i = b_rd; i < rd_log.size(); i++)
                if (rd_log[i] == 16'h0000 || rd_log[i] == 16'h0100) bad++;
            chk("pFF_nowrap", bad, 0);
        end

        // re-trigger mid-transfer ignored
        snap(); trig(8'h02, 1'b0);
        repeat (50) @(negedge clk);
        cpu_wr(16'h4014, 8'h03);
        repeat (560) @(negedge clk);
        check_xfer("retrig", 8'h02, 1'b0);

        // trigger in the DONE cycle ignored
        snap(); trig(8'h02, 1'b0);
        hit = 0;
        for (int i = 0; i < 700 && !hit; i++) begin
            @(negedge clk);
            if (dma_done) hit = 1;
        end
        chk("donetrig_seen", hit, 1);
        cpu_wr(16'h4014, 8'h05);
        repeat (20) @(negedge clk);
        chk("donetrig_done", done_cnt - b_done, 1);
        chk("donetrig_nwr", wr_log.size() - b_wr, 256);
        chk("donetrig_rdy", rdy, 1);

        // reset during the 100th write
        snap(); trig(8'h02, 1'b0);
        w = 0; hit = 0;
        for (int i = 0; i < 700 && !hit; i++) begin
            @(negedge clk);
            if (bus_oe && !bus_r_w_n) w++;
            if (w == 100) hit = 1;
        end
        chk("mrst_reach", hit, 1);
        reset = 1'b1;
        #1;
        chk("mrst_in_rdy", rdy, 1);
        chk("mrst_in_oe", bus_oe, 0);
        chk("mrst_in_rwn", bus_r_w_n, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_rdy", rdy, 1);
        chk("mrst_oe", bus_oe, 0);
        repeat (10) @(negedge clk);
        chk("mrst_nodone", done_cnt - b_done, 0);
        snap(); trig(8'h02, 1'b0); repeat (600) @(negedge clk);
        check_xfer("after_rst", 8'h02, 1'b0);

        // non-trigger accesses
        snap();
        cpu_addr = 16'h4014; cpu_d = 8'h02; cpu_r_w_n = 1'b1;
        @(negedge clk);
        cpu_wr(16'h4015, 8'h02);
        repeat (20) @(negedge clk);
        chk("notrig_rdylow", rdy_low - b_rdy, 0);
        chk("notrig_rd", rd_log.size() - b_rd, 0);
        chk("notrig_rdy", rdy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
